aes_inv_key_sched: RTL and testbench
====================================

# aes_inv_key_sched

Inverse AES-128 key schedule for the decryption datapath. It is loaded with the final (round-10) round key and walks the expansion backwards, emitting round keys 10, 9, … 0 in that order. Each key is presented on a valid/ready handshake so the inverse-cipher round logic can consume one key per round. The round constant is regenerated internally, in reverse, by inverse xtime; no lookup of the round number is needed.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  load request; sampled only in IDLE
- last_key  in  128  round-10 key, word w0 = [127:96]; captured when start is accepted
- key_ready  in  1  consumer accepts round_key this cycle
- round_key  out  128  current round key, same word order as last_key
- key_round  out  4  round index of round_key (10 down to 0)
- key_valid  out  1  round_key/key_round valid
- busy  out  1  high from start acceptance until the done cycle, inclusive
- done  out  1  one-cycle pulse after round 0 key is accepted

## Operation
- States: IDLE, OUT (key_valid=1, awaiting key_ready), CALC (deriving the previous key).
- IDLE and start=1: load key_reg<=last_key, key_round<=10, rcon<=8'h36, busy<=1, go to OUT. start is ignored outside IDLE.
- OUT and key_ready=1 (handshake):
  - if key_round=0: key_valid<=0, busy<=0, done<=1, go to IDLE;
  - else go to CALC.
- OUT and key_ready=0: hold round_key, key_round and key_valid stable.
- CALC derives the previous key from current words w0..w3 and rcon:
  - p3=w3^w2, p2=w2^w1, p1=w1^w0;
  - p0=w0^SubWord(RotWord(p3))^{rcon,24'h0}.
  - RotWord({a,b,c,d})={b,c,d,a}.
  - On completion: key_reg<={p0,p1,p2,p3}, key_round<=key_round-1, rcon<=inv_xtime(rcon), go to OUT.
- inv_xtime(x) = x[0] ? ((x^8'h1b)>>1)|8'h80 : x>>1. This gives the sequence 36,1b,80,40,20,10,08,04,02,01.
- key_round never wraps: it decrements only on a handshake with key_round≠0.
- rst in any state: IDLE, all outputs and internal registers zero, in-flight sequence abandoned. A start asserted in the same cycle as rst is dropped.

## Timing
- Reset values: round_key=0, key_round=0, key_valid=0, busy=0, done=0.
- Start to first key_valid: 1 cycle (round-10 key visible the cycle after start is sampled).
- Handshake to next key_valid: 1 cycle (parallel S-box) or 4 cycles (serial S-box). key_valid is low during CALC.
- Full sequence with key_ready tied high: 1 + 11 + 10·L cycles from start to done, where L=1 (parallel) or L=4 (serial).
- done is asserted the cycle after the round-0 handshake; busy falls in that same cycle. A new start may be accepted in the cycle after done.

## Configuration
- AES_INV_KS_SERIAL_SBOX_EN
  - Defined: one S-box instance is time-shared over the four bytes of RotWord(p3), one byte per cycle, indexed by a 2-bit counter. CALC lasts exactly 4 cycles. Partial SubWord bytes are held in a 24-bit register; key_reg updates on the 4th cycle.
  - Undefined: four S-box instances; CALC lasts exactly 1 cycle.
- Key sequence and handshake behaviour are identical in both builds; only latency differs.

## Test plan
- FIPS-197 vector: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1.
  - Key 10 = last_key.
  - Key 9 = ac7766f319fadc2128d12941575c006e.
  - Key 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - done 1+11+10·L cycles after start.
- Backpressure: drop key_ready for 5 cycles while key_round=7.
  - round_key, key_round and key_valid stay stable.
  - The sequence resumes unchanged and ends with the same round-0 key.
- Start while busy: pulse start with a different last_key at key_round=5. The pulse is ignored and the output sequence is unchanged.
- Reset mid-sequence: assert rst at key_round=4.
  - Next cycle all outputs are 0 and the block is in IDLE.
  - A new start then produces the full 10..0 sequence from round 10.
- Back-to-back: start in the cycle after done. Second run is correct, including rcon restarting at 36.
- All-zero last_key: compare every emitted key against a reference model. Verifies rcon and S-box paths for all 11 keys in both macro builds.

Source files
------------

// File: rtl/aes_inv_key_sched_if.sv
// +----------------------------------------------------------------------------+
// | aes_inv_key_sched_if                                                        |
// | Start/load and round-key valid/ready bundle for aes_inv_key_sched.          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface aes_inv_key_sched_if;
  logic         start;
  logic [127:0] last_key;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   key_round;
  logic         key_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, last_key, key_ready,
    input  round_key, key_round, key_valid, busy, done
  );

  modport slave (
    input  start, last_key, key_ready,
    output round_key, key_round, key_valid, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/aes_inv_key_sched.sv
// +----------------------------------------------------------------------------+
// | aes_inv_key_sched                                                           |
// | Inverse AES-128 key schedule: emits round keys 10..0 on a valid/ready       |
// | handshake. Define AES_INV_KS_SERIAL_SBOX_EN for a single time-shared S-box. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_inv_key_sched (
  input  wire logic          clk,
  input  wire logic          rst,
  aes_inv_key_sched_if.slave ks
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OUT  = 2'd1,
    S_CALC = 2'd2
  } state_t;

  localparam logic [7:0] C_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return C_SBOX[x];
  endfunction

  // Inverse of xtime: walks the round constant backwards 36 -> 1b -> 80 ... -> 01.
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    logic [7:0] y;
    y = x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
    return y;
  endfunction

  state_t       r_state, w_state_nxt;
  logic [127:0] r_key,   w_key_nxt;
  logic [3:0]   r_round, w_round_nxt;
  logic [7:0]   r_rcon,  w_rcon_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_busy,  w_busy_nxt;
  logic         r_done,  w_done_nxt;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_p0, w_p1, w_p2, w_p3;
  logic [31:0]  w_rot;
  logic [31:0]  w_subword;
  logic [127:0] w_prev;
  logic         w_calc_done;

  assign w_w0  = r_key[127:96];
  assign w_w1  = r_key[95:64];
  assign w_w2  = r_key[63:32];
  assign w_w3  = r_key[31:0];

  assign w_p3  = w_w3 ^ w_w2;
  assign w_p2  = w_w2 ^ w_w1;
  assign w_p1  = w_w1 ^ w_w0;
  assign w_rot = {w_p3[23:0], w_p3[31:24]};
  assign w_p0  = w_w0 ^ w_subword ^ {r_rcon, 24'h0};
  assign w_prev = {w_p0, w_p1, w_p2, w_p3};

`ifdef AES_INV_KS_SERIAL_SBOX_EN
  // One S-box walks RotWord(p3) MSB byte first; earlier results shift through r_sub.
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic [23:0] r_sub, w_sub_nxt;
  logic [7:0]  w_sbyte_in;
  logic [7:0]  w_sbyte_out;

  always_comb begin
    w_sbyte_in = w_rot[31:24];
    case (r_cnt)
      2'd0:    w_sbyte_in = w_rot[31:24];
      2'd1:    w_sbyte_in = w_rot[23:16];
      2'd2:    w_sbyte_in = w_rot[15:8];
      default: w_sbyte_in = w_rot[7:0];
    endcase
  end

  assign w_sbyte_out = sbox(w_sbyte_in);
  assign w_subword   = {r_sub, w_sbyte_out};
  assign w_calc_done = (r_cnt == 2'd3);
`else
  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign w_subword[8*gi +: 8] = sbox(w_rot[8*gi +: 8]);
  end
  assign w_calc_done = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_round_nxt = r_round;
    w_rcon_nxt  = r_rcon;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef AES_INV_KS_SERIAL_SBOX_EN
    w_cnt_nxt   = r_cnt;
    w_sub_nxt   = r_sub;
`endif
    case (r_state)
      S_IDLE: begin
        if (ks.start) begin
          w_key_nxt   = ks.last_key;
          w_round_nxt = 4'd10;
          w_rcon_nxt  = 8'h36;
          w_busy_nxt  = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (ks.key_ready) begin
          w_valid_nxt = 1'b0;
          if (r_round == 4'd0) begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
`ifdef AES_INV_KS_SERIAL_SBOX_EN
        w_cnt_nxt = r_cnt + 2'd1;
        w_sub_nxt = {r_sub[15:0], w_sbyte_out};
`endif
        if (w_calc_done) begin
          w_key_nxt   = w_prev;
          w_round_nxt = r_round - 4'd1;
          w_rcon_nxt  = inv_xtime(r_rcon);
          w_valid_nxt = 1'b1;
          w_state_nxt = S_OUT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_key   <= 128'h0;
      r_round <= 4'd0;
      r_rcon  <= 8'h00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef AES_INV_KS_SERIAL_SBOX_EN
      r_cnt   <= 2'd0;
      r_sub   <= 24'h0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_round <= w_round_nxt;
      r_rcon  <= w_rcon_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef AES_INV_KS_SERIAL_SBOX_EN
      r_cnt   <= w_cnt_nxt;
      r_sub   <= w_sub_nxt;
`endif
    end
  end

  assign ks.round_key = r_key;
  assign ks.key_round = r_round;
  assign ks.key_valid = r_valid;
  assign ks.busy      = r_busy;
  assign ks.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_key_sched.sv
// +----------------------------------------------------------------------------+
// | tb_aes_inv_key_sched                                                        |
// | Scoreboard bench for aes_inv_key_sched against a forward-rule AES model.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_aes_inv_key_sched;

`ifdef AES_INV_KS_SERIAL_SBOX_EN
  localparam int L = 4;
`else
  localparam int L = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_inv_key_sched_if ks ();
  aes_inv_key_sched dut (.clk(clk), .rst(rst), .ks(ks));

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   rnd;
  } exp_t;

  exp_t         exp_q [$];
  exp_t         mon_e;
  int           n_checks = 0;
  int           n_err    = 0;
  bit           bp_req   = 1'b0;
  bit           rand_rdy = 1'b0;
  logic [127:0] m_keys [0:10];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // GF(2^8) arithmetic used to build the S-box from its definition.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] inv, s;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    if (a == 8'h00) inv = 8'h00;
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  // Undo w[i] = w[i-4] ^ temp(w[i-1]) for i = 43 down to 4.
  task automatic model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [7:0]  rc [1:10];
    logic [31:0] t;
    logic [7:0]  r;
    r = 8'h01;
    for (int j = 1; j <= 10; j++) begin
      rc[j] = r;
      r = xt(r);
    end
    w[40] = k[127:96];
    w[41] = k[95:64];
    w[42] = k[63:32];
    w[43] = k[31:0];
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) t = subword({t[23:0], t[31:24]}) ^ {rc[i/4], 24'h0};
      w[i-4] = w[i] ^ t;
    end
    for (int rr = 0; rr <= 10; rr++) m_keys[rr] = {w[4*rr], w[4*rr+1], w[4*rr+2], w[4*rr+3]};
  endtask

  always @(negedge clk) begin
    if (!rst && ks.key_valid && ks.key_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_key", ks.round_key, 128'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("round_key", ks.round_key, mon_e.key);
        check("key_round", 128'(ks.key_round), 128'(mon_e.rnd));
      end
    end
  end

  // key_ready driver; also holds off the round-7 key for five cycles on request.
  initial begin
    logic [127:0] cap_key;
    logic [3:0]   cap_rnd;
    ks.key_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_req && !rst && ks.key_valid && ks.key_round == 4'd7) begin
        ks.key_ready = 1'b0;
        cap_key = ks.round_key;
        cap_rnd = ks.key_round;
        repeat (5) begin
          @(posedge clk);
          #1;
          check("bp_key_stable",   ks.round_key, cap_key);
          check("bp_round_stable", 128'(ks.key_round), 128'(cap_rnd));
          check("bp_valid_stable", 128'(ks.key_valid), 128'd1);
        end
        ks.key_ready = 1'b1;
        bp_req = 1'b0;
      end else begin
        ks.key_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_round_key"}, ks.round_key, 128'h0);
    check({tag, "_key_round"}, 128'(ks.key_round), 128'h0);
    check({tag, "_key_valid"}, 128'(ks.key_valid), 128'h0);
    check({tag, "_busy"},      128'(ks.busy), 128'h0);
    check({tag, "_done"},      128'(ks.done), 128'h0);
  endtask

  // mode: 0 plain + latency, 1 backpressure, 2 start while busy, 3 reset at round 4, 4 random ready
  task automatic run_seq(input logic [127:0] k, input int mode);
    int   cyc;
    bit   seen_done, aborted, pulsed;
    exp_t e;
    model(k);
    for (int r = 10; r >= 0; r--) begin
      e.key = m_keys[r];
      e.rnd = 4'(r);
      exp_q.push_back(e);
    end
    rand_rdy = (mode == 4);
    bp_req   = (mode == 1);
    @(posedge clk);
    #1;
    ks.start    = 1'b1;
    ks.last_key = k;
    @(posedge clk);
    #1;
    ks.start = 1'b0;
    cyc = 1;
    seen_done = 1'b0;
    aborted = 1'b0;
    pulsed = 1'b0;
    check("first_valid", 128'(ks.key_valid), 128'd1);
    check("first_round", 128'(ks.key_round), 128'd10);
    check("busy_on",     128'(ks.busy), 128'd1);
    while (!seen_done && !aborted && cyc < 2000) begin
      if (mode == 2 && !pulsed && ks.key_valid && ks.key_round == 4'd5) begin
        ks.start    = 1'b1;
        ks.last_key = ~k;
        pulsed      = 1'b1;
      end else begin
        ks.start = 1'b0;
      end
      if (mode == 3 && ks.key_valid && ks.key_round == 4'd4) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("mid_rst");
        exp_q.delete();
        aborted = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
        if (ks.done) begin
          seen_done = 1'b1;
          check("busy_off_at_done", 128'(ks.busy), 128'd0);
          check("valid_off_at_done", 128'(ks.key_valid), 128'd0);
        end
      end
    end
    ks.start = 1'b0;
    if (!aborted) begin
      check("done_seen_or_timeout", 128'(seen_done), 128'd1);
      if (mode == 0) check("start_to_done_latency", 128'(cyc), 128'(12 + 10 * L));
      check("all_keys_emitted", 128'(exp_q.size()), 128'd0);
    end
    if (mode == 1) check("bp_window_taken", 128'(bp_req), 128'd0);
    if (mode == 2) check("busy_start_pulsed", 128'(pulsed), 128'd1);
    rand_rdy = 1'b0;
  endtask

  localparam logic [127:0] C_FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    rst         = 1'b1;
    ks.start    = 1'b0;
    ks.last_key = 128'h0;
    repeat (2) @(posedge clk);
    #1;
    ks.start    = 1'b1;
    ks.last_key = C_FIPS10;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    ks.start = 1'b0;
    check_zero("reset");
    @(posedge clk);
    #1;
    check("start_in_rst_dropped_valid", 128'(ks.key_valid), 128'd0);
    check("start_in_rst_dropped_busy",  128'(ks.busy), 128'd0);

    model(C_FIPS10);
    check("fips_model_key9", m_keys[9], 128'hac7766f319fadc2128d12941575c006e);
    check("fips_model_key0", m_keys[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    run_seq(C_FIPS10, 0);
    run_seq(C_FIPS10, 1);
    run_seq(C_FIPS10, 2);
    run_seq({$urandom, $urandom, $urandom, $urandom}, 3);
    run_seq({$urandom, $urandom, $urandom, $urandom}, 0);
    run_seq({$urandom, $urandom, $urandom, $urandom}, 0);
    run_seq(128'h0, 0);
    for (int n = 0; n < 4; n++) run_seq({$urandom, $urandom, $urandom, $urandom}, 4);

    repeat (3) @(posedge clk);
    #1;
    check("idle_at_end", 128'(ks.busy), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
